// File: rtl/instr_ram_arbiter_if.sv
// Bundle of the core fetch port, debug/loader port and single-port RAM port
// that meet at the instruction RAM arbiter.
interface instr_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 17
);
  logic                  core_req_i;
  logic [ADDR_WIDTH-1:0] core_addr_i;
  logic                  core_gnt_o;
  logic                  core_rvalid_o;
  logic [31:0]           core_rdata_o;

  logic                  dbg_req_i;
  logic [ADDR_WIDTH-1:0] dbg_addr_i;
  logic                  dbg_we_i;
  logic [3:0]            dbg_be_i;
  logic [31:0]           dbg_wdata_i;
  logic                  dbg_gnt_o;
  logic                  dbg_rvalid_o;
  logic [31:0]           dbg_rdata_o;
  logic                  dbg_err_o;

  logic                  ram_en_o;
  logic [ADDR_WIDTH-1:0] ram_addr_o;
  logic [31:0]           ram_wdata_o;
  logic                  ram_we_o;
  logic [3:0]            ram_be_o;
  logic [31:0]           ram_rdata_i;

  // Handshake: a request is accepted in the cycle where req and gnt are both
  // high; its single rvalid pulse follows exactly one cycle later.
  modport slave (
    input  core_req_i, core_addr_i,
    input  dbg_req_i, dbg_addr_i, dbg_we_i, dbg_be_i, dbg_wdata_i,
    input  ram_rdata_i,
    output core_gnt_o, core_rvalid_o, core_rdata_o,
    output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, dbg_err_o,
    output ram_en_o, ram_addr_o, ram_wdata_o, ram_we_o, ram_be_o
  );

  modport master (
    output core_req_i, core_addr_i,
    output dbg_req_i, dbg_addr_i, dbg_we_i, dbg_be_i, dbg_wdata_i,
    output ram_rdata_i,
    input  core_gnt_o, core_rvalid_o, core_rdata_o,
    input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, dbg_err_o,
    input  ram_en_o, ram_addr_o, ram_wdata_o, ram_we_o, ram_be_o
  );
endinterface

// File: rtl/instr_ram_arbiter.sv
// Two-port arbiter in front of a 1-cycle instruction RAM: core fetches win by
// default, debug is force-granted after MAX_WAIT lost cycles.
module instr_ram_arbiter #(
  parameter int ADDR_WIDTH = 17,
  parameter int MAX_WAIT   = 8
) (
  input logic                 clk,
  input logic                 rst,
  instr_ram_arbiter_if.slave  bus
);

  logic [7:0] r_starve;
  logic       r_rsp_core;
  logic       r_rsp_dbg;
  logic       r_dbg_rd;
  logic       r_err;

  logic       w_force;
  logic       w_dbg_gnt;
  logic       w_core_gnt;
  logic       w_dbg_prot;
  logic       w_dbg_ram;

  assign w_force    = (r_starve == 8'(MAX_WAIT));
  assign w_dbg_gnt  = bus.dbg_req_i & (~bus.core_req_i | w_force);
  assign w_core_gnt = bus.core_req_i & ~w_dbg_gnt;
  // Writes into the top half of the address space hit the boot ROM image.
  assign w_dbg_prot = bus.dbg_we_i & bus.dbg_addr_i[ADDR_WIDTH-1];
  assign w_dbg_ram  = w_dbg_gnt & ~w_dbg_prot;

  assign bus.core_gnt_o = w_core_gnt;
  assign bus.dbg_gnt_o  = w_dbg_gnt;

  always_comb begin
    bus.ram_en_o    = 1'b0;
    bus.ram_addr_o  = '0;
    bus.ram_wdata_o = 32'h0;
    bus.ram_we_o    = 1'b0;
    bus.ram_be_o    = 4'h0;
    if (w_core_gnt) begin
      bus.ram_en_o   = 1'b1;
      bus.ram_addr_o = bus.core_addr_i;
      bus.ram_be_o   = 4'hF;
    end else if (w_dbg_ram) begin
      bus.ram_en_o    = 1'b1;
      bus.ram_addr_o  = bus.dbg_addr_i;
      bus.ram_wdata_o = bus.dbg_wdata_i;
      bus.ram_we_o    = bus.dbg_we_i;
      bus.ram_be_o    = bus.dbg_be_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve   <= 8'h0;
      r_rsp_core <= 1'b0;
      r_rsp_dbg  <= 1'b0;
      r_dbg_rd   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (~bus.dbg_req_i | w_dbg_gnt) begin
        r_starve <= 8'h0;
      end else if (!w_force) begin
        r_starve <= r_starve + 8'h1;
      end
      r_rsp_core <= w_core_gnt;
      r_rsp_dbg  <= w_dbg_gnt;
      r_dbg_rd   <= w_dbg_gnt & ~bus.dbg_we_i;
      r_err      <= w_dbg_gnt & w_dbg_prot;
    end
  end

  // A response due in a reset cycle is suppressed, not merely delayed.
  assign bus.core_rvalid_o = r_rsp_core & ~rst;
  assign bus.dbg_rvalid_o  = r_rsp_dbg & ~rst;
  assign bus.dbg_err_o     = r_rsp_dbg & r_err & ~rst;
  assign bus.core_rdata_o  = bus.core_rvalid_o ? bus.ram_rdata_i : 32'h0;
  assign bus.dbg_rdata_o   = (bus.dbg_rvalid_o & r_dbg_rd) ? bus.ram_rdata_i : 32'h0;

endmodule

// File: tb/tb_instr_ram_arbiter.sv
// Directed bench for instr_ram_arbiter with a small behavioural RAM behind it.
module tb_instr_ram_arbiter;
  localparam int AW = 17;
  localparam int MW = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  instr_ram_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  instr_ram_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // RAM model: word index from addr[9:2], 1-cycle read, byte-enabled write.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      bus.ram_rdata_i <= 32'h0;
    end else if (bus.ram_en_o) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_we_o && bus.ram_be_o[b])
          mem[bus.ram_addr_o[9:2]][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
      bus.ram_rdata_i <= mem[bus.ram_addr_o[9:2]];
    end
  end

  task automatic set_in(input logic cr, input logic [AW-1:0] ca, input logic dr,
                        input logic [AW-1:0] da, input logic dwe, input logic [3:0] dbe,
                        input logic [31:0] dwd);
    bus.core_req_i  = cr;
    bus.core_addr_i = ca;
    bus.dbg_req_i   = dr;
    bus.dbg_addr_i  = da;
    bus.dbg_we_i    = dwe;
    bus.dbg_be_i    = dbe;
    bus.dbg_wdata_i = dwd;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic cycle_idle();
    @(negedge clk);
    set_in(1'b0, '0, 1'b0, '0, 1'b0, 4'h0, 32'h0);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1'b0, '0, 1'b0, '0, 1'b0, 4'h0, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.core_gnt_o, bus.dbg_gnt_o, bus.core_rvalid_o, bus.dbg_rvalid_o,
         bus.dbg_err_o, bus.ram_en_o, bus.ram_we_o} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 0000000", {bus.core_gnt_o, bus.dbg_gnt_o,
               bus.core_rvalid_o, bus.dbg_rvalid_o, bus.dbg_err_o, bus.ram_en_o, bus.ram_we_o});
    end
    checks++;
    if ({bus.core_rdata_o, bus.dbg_rdata_o} !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata got %h %h exp 0 0", bus.core_rdata_o, bus.dbg_rdata_o);
    end
  endtask

  task automatic test_core_read();
    cycle_idle();
    @(negedge clk);
    set_in(1'b1, 17'h00100, 1'b0, '0, 1'b0, 4'h0, 32'h0);
    #1;
    checks++;
    if ({bus.core_gnt_o, bus.dbg_gnt_o, bus.ram_en_o, bus.ram_we_o} !== 4'b1010) begin
      errors++;
      $display("FAIL core_gnt got %b exp 1010",
               {bus.core_gnt_o, bus.dbg_gnt_o, bus.ram_en_o, bus.ram_we_o});
    end
    checks++;
    if (bus.ram_addr_o !== 17'h00100 || bus.ram_be_o !== 4'hF) begin
      errors++;
      $display("FAIL core_ram got addr %h be %h exp 00100 f", bus.ram_addr_o, bus.ram_be_o);
    end
    cycle_idle();
    checks++;
    if (bus.core_rvalid_o !== 1'b1 || bus.dbg_rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL core_rvalid got %b%b exp 10", bus.core_rvalid_o, bus.dbg_rvalid_o);
    end
    checks++;
    if (bus.core_rdata_o !== 32'hA500_0040) begin
      errors++;
      $display("FAIL core_rdata got %h exp a5000040", bus.core_rdata_o);
    end
    checks++;
    if ({bus.ram_en_o, bus.ram_we_o, bus.ram_addr_o, bus.ram_be_o, bus.ram_wdata_o} !== '0) begin
      errors++;
      $display("FAIL idle_ram got en %b addr %h be %h wd %h exp all 0",
               bus.ram_en_o, bus.ram_addr_o, bus.ram_be_o, bus.ram_wdata_o);
    end
    cycle_idle();
    checks++;
    if (bus.core_rvalid_o !== 1'b0 || bus.core_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL core_single_rvalid got %b %h exp 0 0", bus.core_rvalid_o, bus.core_rdata_o);
    end
  endtask

  task automatic test_write_read();
    cycle_idle();
    @(negedge clk);
    set_in(1'b0, '0, 1'b1, 17'h00040, 1'b1, 4'hF, 32'hDEAD_BEEF);
    #1;
    checks++;
    if ({bus.dbg_gnt_o, bus.ram_en_o, bus.ram_we_o, bus.ram_be_o} !== 7'b1111111 ||
        bus.ram_addr_o !== 17'h00040 || bus.ram_wdata_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL dbg_write got gnt %b en %b we %b be %h addr %h wd %h exp 1 1 1 f 00040 deadbeef",
               bus.dbg_gnt_o, bus.ram_en_o, bus.ram_we_o, bus.ram_be_o, bus.ram_addr_o, bus.ram_wdata_o);
    end
    @(negedge clk);
    set_in(1'b0, '0, 1'b1, 17'h00040, 1'b0, 4'hF, 32'h0);
    #1;
    checks++;
    if ({bus.dbg_rvalid_o, bus.dbg_err_o} !== 2'b10 || bus.dbg_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL dbg_write_rsp got rv %b err %b rd %h exp 1 0 0",
               bus.dbg_rvalid_o, bus.dbg_err_o, bus.dbg_rdata_o);
    end
    checks++;
    if ({bus.dbg_gnt_o, bus.ram_en_o, bus.ram_we_o} !== 3'b110) begin
      errors++;
      $display("FAIL dbg_read_gnt got %b exp 110", {bus.dbg_gnt_o, bus.ram_en_o, bus.ram_we_o});
    end
    cycle_idle();
    checks++;
    if ({bus.dbg_rvalid_o, bus.dbg_err_o} !== 2'b10 || bus.dbg_rdata_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL dbg_readback got rv %b err %b rd %h exp 1 0 deadbeef",
               bus.dbg_rvalid_o, bus.dbg_err_o, bus.dbg_rdata_o);
    end
  endtask

  task automatic test_protected();
    cycle_idle();
    @(negedge clk);
    set_in(1'b0, '0, 1'b1, 17'h10000, 1'b1, 4'hF, 32'h1234_5678);
    #1;
    checks++;
    if ({bus.dbg_gnt_o, bus.ram_en_o, bus.ram_we_o} !== 3'b100 ||
        {bus.ram_addr_o, bus.ram_be_o, bus.ram_wdata_o} !== '0) begin
      errors++;
      $display("FAIL prot_gnt got gnt %b en %b we %b addr %h exp 1 0 0 0",
               bus.dbg_gnt_o, bus.ram_en_o, bus.ram_we_o, bus.ram_addr_o);
    end
    // Reads of the protected region are ordinary RAM reads.
    @(negedge clk);
    set_in(1'b0, '0, 1'b1, 17'h10000, 1'b0, 4'hF, 32'h0);
    #1;
    checks++;
    if ({bus.dbg_rvalid_o, bus.dbg_err_o} !== 2'b11 || bus.dbg_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL prot_rsp got rv %b err %b rd %h exp 1 1 0",
               bus.dbg_rvalid_o, bus.dbg_err_o, bus.dbg_rdata_o);
    end
    checks++;
    if (bus.ram_en_o !== 1'b1 || bus.ram_addr_o !== 17'h10000) begin
      errors++;
      $display("FAIL prot_read_en got en %b addr %h exp 1 10000", bus.ram_en_o, bus.ram_addr_o);
    end
    cycle_idle();
    checks++;
    if ({bus.dbg_rvalid_o, bus.dbg_err_o} !== 2'b10 || bus.dbg_rdata_o !== 32'hA500_0000) begin
      errors++;
      $display("FAIL prot_read_rsp got rv %b err %b rd %h exp 1 0 a5000000",
               bus.dbg_rvalid_o, bus.dbg_err_o, bus.dbg_rdata_o);
    end
    cycle_idle();
    checks++;
    if (bus.dbg_err_o !== 1'b0 || bus.dbg_rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL prot_err_clear got rv %b err %b exp 0 0", bus.dbg_rvalid_o, bus.dbg_err_o);
    end
  endtask

  // Both ports request every cycle: debug wins cycles 8, 17, 26.
  task automatic test_back_to_back();
    logic prev_dbg;
    logic exp_dbg;
    cycle_idle();
    prev_dbg = 1'b0;
    for (int c = 0; c < 27; c++) begin
      @(negedge clk);
      set_in(1'b1, 17'h00100, 1'b1, 17'h00080, 1'b0, 4'hF, 32'h0);
      #1;
      exp_dbg = ((c % 9) == 8);
      checks++;
      if (bus.dbg_gnt_o !== exp_dbg || bus.core_gnt_o !== !exp_dbg) begin
        errors++;
        $display("FAIL b2b_gnt c=%0d got core %b dbg %b exp core %b dbg %b",
                 c, bus.core_gnt_o, bus.dbg_gnt_o, !exp_dbg, exp_dbg);
      end
      if (c > 0) begin
        checks++;
        if (bus.dbg_rvalid_o !== prev_dbg || bus.core_rvalid_o !== !prev_dbg ||
            bus.core_rdata_o !== (prev_dbg ? 32'h0 : 32'hA500_0040) ||
            bus.dbg_rdata_o !== (prev_dbg ? 32'hA500_0020 : 32'h0)) begin
          errors++;
          $display("FAIL b2b_rsp c=%0d got crv %b cd %h drv %b dd %h exp drv %b",
                   c, bus.core_rvalid_o, bus.core_rdata_o, bus.dbg_rvalid_o, bus.dbg_rdata_o, prev_dbg);
        end
      end
      prev_dbg = exp_dbg;
    end
    cycle_idle();
    checks++;
    if (bus.dbg_rvalid_o !== 1'b1 || bus.dbg_rdata_o !== 32'hA500_0020 || bus.core_rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_last got drv %b dd %h crv %b exp 1 a5000020 0",
               bus.dbg_rvalid_o, bus.dbg_rdata_o, bus.core_rvalid_o);
    end
  endtask

  // Dropping dbg_req for one cycle restarts the full wait.
  task automatic test_starve_clear();
    cycle_idle();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      set_in(1'b1, 17'h00100, 1'b1, 17'h00080, 1'b0, 4'hF, 32'h0);
    end
    @(negedge clk);
    set_in(1'b1, 17'h00100, 1'b0, 17'h00080, 1'b0, 4'hF, 32'h0);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      set_in(1'b1, 17'h00100, 1'b1, 17'h00080, 1'b0, 4'hF, 32'h0);
      #1;
      checks++;
      if (bus.dbg_gnt_o !== (c == 8)) begin
        errors++;
        $display("FAIL starve_clear c=%0d got dbg_gnt %b exp %b", c, bus.dbg_gnt_o, (c == 8));
      end
    end
    cycle_idle();
  endtask

  task automatic test_reset_mid();
    cycle_idle();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      set_in(1'b1, 17'h00100, 1'b1, 17'h00080, 1'b0, 4'hF, 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    set_in(1'b1, 17'h00100, 1'b0, '0, 1'b0, 4'h0, 32'h0);
    #1;
    checks++;
    if (bus.core_rvalid_o !== 1'b0 || bus.core_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_rvalid got %b %h exp 0 0", bus.core_rvalid_o, bus.core_rdata_o);
    end
    @(negedge clk);
    rst = 1'b0;
    set_in(1'b0, '0, 1'b0, '0, 1'b0, 4'h0, 32'h0);
    #1;
    checks++;
    if ({bus.core_rvalid_o, bus.dbg_rvalid_o, bus.dbg_err_o, bus.ram_en_o} !== 4'b0) begin
      errors++;
      $display("FAIL rst_mid_drop got %b exp 0000",
               {bus.core_rvalid_o, bus.dbg_rvalid_o, bus.dbg_err_o, bus.ram_en_o});
    end
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      set_in(1'b1, 17'h00100, 1'b1, 17'h00080, 1'b0, 4'hF, 32'h0);
      #1;
      checks++;
      if (bus.dbg_gnt_o !== (c == 8) || bus.core_gnt_o !== (c != 8)) begin
        errors++;
        $display("FAIL rst_mid_starve c=%0d got core %b dbg %b exp dbg %b",
                 c, bus.core_gnt_o, bus.dbg_gnt_o, (c == 8));
      end
    end
    cycle_idle();
  endtask

  task automatic test_dbg_alone();
    cycle_idle();
    @(negedge clk);
    set_in(1'b0, '0, 1'b1, 17'h00080, 1'b0, 4'hF, 32'h0);
    #1;
    checks++;
    if ({bus.dbg_gnt_o, bus.core_gnt_o, bus.ram_en_o} !== 3'b101 || bus.ram_addr_o !== 17'h00080) begin
      errors++;
      $display("FAIL dbg_alone got dbg %b core %b en %b addr %h exp 1 0 1 00080",
               bus.dbg_gnt_o, bus.core_gnt_o, bus.ram_en_o, bus.ram_addr_o);
    end
    cycle_idle();
    checks++;
    if (bus.dbg_rvalid_o !== 1'b1 || bus.dbg_rdata_o !== 32'hA500_0020) begin
      errors++;
      $display("FAIL dbg_alone_rsp got %b %h exp 1 a5000020", bus.dbg_rvalid_o, bus.dbg_rdata_o);
    end
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_write_read();
    test_protected();
    test_dbg_alone();
    test_back_to_back();
    test_starve_clear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
